// File: rtl/rv32_pkg.sv
// Shared register-file constants and the register-index type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: default data width, default register count, register index type.
package rv32_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int REG_AW_DEF = $clog2(NREGS_DEF);

    typedef logic [REG_AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy bits with reservation, writeback clear and flush.
// Latency: rsv_ok/rd_busy combinational; busy bits and busy_cnt update on the next edge.
// Backpressure: a reservation on a busy register is refused (rsv_ok=0) and changes no state.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   upd_en            state may update on this edge (low on the reset-release edge)
//   wb_en, wb_addr    writeback clears the target busy bit
//   rsv_en, rsv_addr  reservation request; rsv_ok is the combinational grant
//   flush             clears every busy bit, overriding a same-cycle reservation
//   rd_addr, rd_busy  per-read-port busy lookup
//   busy_cnt          registered popcount of the busy bits
module regfile_busy_tracker
    import rv32_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upd_en,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic              rsv_ok,
    output logic [NRD-1:0]    rd_busy,
    output logic [AW:0]       busy_cnt
);

    localparam int CW = AW + 1;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_nxt;
    logic [CW-1:0]    cnt_nxt;

    // A same-cycle writeback to the target frees it, so the reservation may
    // take over; register 0 is never tracked and is always grantable.
    assign rsv_ok = rsv_en && ((rsv_addr == '0) || !busy_q[rsv_addr] ||
                               (wb_en && (wb_addr == rsv_addr)));

    // Order matters: the reservation set wins over the writeback clear, and
    // flush wins over both.
    always_comb begin
        busy_nxt = busy_q;
        if (wb_en) begin
            busy_nxt[wb_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
        if (flush) begin
            busy_nxt = '0;
        end
    end

    // Popcount of the post-edge state so busy_cnt matches busy_q exactly.
    // Bit 0 is excluded, so the count tops out at NREGS-1 and never wraps.
    always_comb begin
        cnt_nxt = '0;
        for (int k = 1; k < NREGS; k++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            busy_cnt <= '0;
        end else if (upd_en) begin
            busy_q   <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // A read that is bypassed from the current writeback sees the final
    // value, so it is not reported busy.
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_busy
        logic [AW-1:0] addr;
        assign addr        = rd_addr[gi*AW +: AW];
        assign rd_busy[gi] = busy_q[addr] && !(wb_en && (wb_addr == addr));
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with writeback bypass and a per-register reservation scoreboard.
// Latency: reads, rd_busy and rsv_ok combinational; writes and busy state update on the next edge.
// Backpressure: rsv_ok=0 when the destination already has an outstanding reservation.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   rd_addr, rd_data, rd_busy  NRD read ports (packed, port i at [i*W +: W])
//   wb_en, wb_addr, wb_data    writeback; x0 writes are dropped
//   rsv_en, rsv_addr, rsv_ok   destination reservation request and grant
//   flush                      drop all pending reservations
//   busy_cnt                   number of reserved registers (registered)
module regfile_scoreboard
    import rv32_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ok,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic            run_q;
    logic [XLEN-1:0] regs_q [NREGS];

    // Reset release is taken on an edge: the first edge after rst_n rises
    // only arms run_q, so no write or reservation lands on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
        end else if (run_q && wb_en && (wb_addr != '0)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr[gi*AW +: AW];
        assign rd_data[gi*XLEN +: XLEN] =
            (addr == '0)                    ? '0      :
            (wb_en && (wb_addr == addr))    ? wb_data :
                                              regs_q[addr];
    end

    regfile_busy_tracker #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_busy (
        .clk      (clk),
        .rst_n    (rst_n),
        .upd_en   (run_q),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .rd_addr  (rd_addr),
        .rsv_ok   (rsv_ok),
        .rd_busy  (rd_busy),
        .busy_cnt (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus random traffic
// against an array-based model of register contents and reservations.
// Runs to a single summary line.
module tb_regfile_scoreboard;
    import rv32_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_ok;
    logic                flush;
    logic [AW:0]         busy_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Model: register contents, reservation flags, and whether edges take effect.
    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_busy [NREGS];
    bit              m_live;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [XLEN-1:0] m_read(input int a);
        if (a == 0) return '0;
        if (wb_en && (int'(wb_addr) == a)) return wb_data;
        return m_mem[a];
    endfunction

    function automatic bit m_rbusy(input int a);
        if (a == 0) return 1'b0;
        if (wb_en && (int'(wb_addr) == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit m_rsv_ok();
        return rsv_en && ((rsv_addr == 0) || !m_busy[rsv_addr] || (wb_en && (wb_addr == rsv_addr)));
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < NREGS; k++) c += int'(m_busy[k]);
        return c;
    endfunction

    function automatic logic [XLEN-1:0] get_rd(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NREGS; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 1'b0;
        end
        m_live = 1'b0;
    endtask

    // One clock edge with the current inputs; the model follows the
    // behavioural rules, then control returns 1 time unit after the edge.
    task automatic tick();
        bit ok;
        ok = m_rsv_ok();
        @(posedge clk);
        if (m_live && rst_n) begin
            if (wb_en && (wb_addr != 0)) begin
                m_mem[wb_addr]  = wb_data;
                m_busy[wb_addr] = 1'b0;
            end
            if (ok && (rsv_addr != 0)) m_busy[rsv_addr] = 1'b1;
            if (flush) for (int k = 0; k < NREGS; k++) m_busy[k] = 1'b0;
        end
        m_live = rst_n;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rd_addr = '0;
        rst_n = 1'b0;
        model_reset();
        // Pending write to x3 across the release edge must be dropped.
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hFF;
        #13;
        n_cmp++;
        if (busy_cnt !== '0) begin
            n_err++; $display("FAIL reset_busy_cnt_held: got %0d expected 0", busy_cnt);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        tick();
        idle();
        for (int r = 1; r < NREGS; r++) begin
            set_rd(0, r);
            set_rd(1, NREGS - r);
            #1;
            n_cmp++;
            if (get_rd(0) !== 32'h0 || get_rd(1) !== 32'h0) begin
                n_err++; $display("FAIL reset_read_x%0d: got %0h/%0h expected 0/0", r, get_rd(0), get_rd(1));
            end
            n_cmp++;
            if (rd_busy !== 2'b00) begin
                n_err++; $display("FAIL reset_rd_busy_x%0d: got %b expected 00", r, rd_busy);
            end
        end
        n_cmp++;
        if (busy_cnt !== '0) begin
            n_err++; $display("FAIL reset_busy_cnt: got %0d expected 0", busy_cnt);
        end
    endtask

    task automatic test_write_bypass();
        idle();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        set_rd(0, 5); set_rd(1, 6);
        #1;
        n_cmp++;
        if (get_rd(0) !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL bypass_same_cycle: got %0h expected deadbeef", get_rd(0));
        end
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (get_rd(0) !== 32'hDEADBEEF) begin
                n_err++; $display("FAIL write_held_cycle%0d: got %0h expected deadbeef", c, get_rd(0));
            end
            tick();
        end
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
        set_rd(0, 0); set_rd(1, 0);
        #1;
        n_cmp++;
        if (get_rd(0) !== 32'h0 || get_rd(1) !== 32'h0) begin
            n_err++; $display("FAIL x0_bypass: got %0h/%0h expected 0/0", get_rd(0), get_rd(1));
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (get_rd(0) !== 32'h0) begin
            n_err++; $display("FAIL x0_write: got %0h expected 0", get_rd(0));
        end
    endtask

    task automatic test_scoreboard();
        idle();
        set_rd(0, 7); set_rd(1, 0);
        rsv_en = 1'b1; rsv_addr = 5'd7;
        #1;
        n_cmp++;
        if (rsv_ok !== 1'b1) begin
            n_err++; $display("FAIL rsv_first: got %b expected 1", rsv_ok);
        end
        tick();
        n_cmp++;
        if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
            n_err++; $display("FAIL rsv_busy_set: got busy=%b cnt=%0d expected busy=1 cnt=1", rd_busy[0], busy_cnt);
        end
        #1;
        n_cmp++;
        if (rsv_ok !== 1'b0) begin
            n_err++; $display("FAIL rsv_refused: got %b expected 0", rsv_ok);
        end
        tick();
        n_cmp++;
        if (busy_cnt !== 6'd1) begin
            n_err++; $display("FAIL rsv_refused_cnt: got %0d expected 1", busy_cnt);
        end
        idle();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL busy_bypass_hit: got %b expected 0", rd_busy[0]);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0 || get_rd(0) !== 32'h55) begin
            n_err++; $display("FAIL wb_clears: got busy=%b cnt=%0d data=%0h expected 0/0/55", rd_busy[0], busy_cnt, get_rd(0));
        end
    endtask

    task automatic test_collision();
        idle();
        set_rd(0, 9); set_rd(1, 9);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hA0;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        #1;
        n_cmp++;
        if (rsv_ok !== 1'b1) begin
            n_err++; $display("FAIL collision_rsv_ok: got %b expected 1", rsv_ok);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (get_rd(0) !== 32'hA0 || rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
            n_err++; $display("FAIL collision_state: got data=%0h busy=%b cnt=%0d expected a0/1/1", get_rd(0), rd_busy[0], busy_cnt);
        end
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hA0;
        tick();
        idle();
    endtask

    task automatic test_flush();
        logic [XLEN-1:0] vals [4];
        vals[0] = 32'h0; vals[1] = 32'h1111; vals[2] = 32'h2222; vals[3] = 32'h3333;
        idle();
        for (int a = 1; a <= 3; a++) begin
            wb_en = 1'b1; wb_addr = AW'(a); wb_data = vals[a];
            tick();
        end
        idle();
        for (int a = 1; a <= 3; a++) begin
            rsv_en = 1'b1; rsv_addr = AW'(a);
            tick();
        end
        idle();
        n_cmp++;
        if (busy_cnt !== 6'd3) begin
            n_err++; $display("FAIL flush_pre_cnt: got %0d expected 3", busy_cnt);
        end
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd4;
        #1;
        n_cmp++;
        if (rsv_ok !== 1'b1) begin
            n_err++; $display("FAIL flush_rsv_ok: got %b expected 1", rsv_ok);
        end
        tick();
        idle();
        n_cmp++;
        if (busy_cnt !== 6'd0) begin
            n_err++; $display("FAIL flush_cnt: got %0d expected 0", busy_cnt);
        end
        for (int a = 1; a <= 4; a++) begin
            set_rd(0, a); set_rd(1, a);
            #1;
            n_cmp++;
            if (rd_busy !== 2'b00) begin
                n_err++; $display("FAIL flush_busy_x%0d: got %b expected 00", a, rd_busy);
            end
            if (a <= 3) begin
                n_cmp++;
                if (get_rd(0) !== vals[a]) begin
                    n_err++; $display("FAIL flush_data_x%0d: got %0h expected %0h", a, get_rd(0), vals[a]);
                end
            end
        end
    endtask

    function automatic int rand_addr();
        if ($urandom_range(1, 0) == 1) return int'($urandom_range(7, 0));
        return int'($urandom_range(NREGS - 1, 0));
    endfunction

    task automatic test_random();
        int ra [NRD];
        for (int it = 0; it < 400; it++) begin
            wb_en    = ($urandom_range(99, 0) < 50);
            wb_addr  = AW'(rand_addr());
            wb_data  = $urandom;
            rsv_en   = ($urandom_range(99, 0) < 60);
            rsv_addr = AW'(rand_addr());
            flush    = ($urandom_range(99, 0) < 3);
            for (int p = 0; p < NRD; p++) begin
                ra[p] = rand_addr();
                set_rd(p, ra[p]);
            end
            #1;
            for (int p = 0; p < NRD; p++) begin
                n_cmp++;
                if (get_rd(p) !== m_read(ra[p])) begin
                    n_err++; $display("FAIL rand_rd_data it%0d p%0d x%0d: got %0h expected %0h", it, p, ra[p], get_rd(p), m_read(ra[p]));
                end
                n_cmp++;
                if (rd_busy[p] !== m_rbusy(ra[p])) begin
                    n_err++; $display("FAIL rand_rd_busy it%0d p%0d x%0d: got %b expected %b", it, p, ra[p], rd_busy[p], m_rbusy(ra[p]));
                end
            end
            n_cmp++;
            if (rsv_ok !== m_rsv_ok()) begin
                n_err++; $display("FAIL rand_rsv_ok it%0d: got %b expected %b", it, rsv_ok, m_rsv_ok());
            end
            tick();
            n_cmp++;
            if (busy_cnt !== (AW+1)'(m_count())) begin
                n_err++; $display("FAIL rand_busy_cnt it%0d: got %0d expected %0d", it, busy_cnt, m_count());
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hCAFE0005;
        tick();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        idle();
        set_rd(0, 5); set_rd(1, 7);
        #1;
        n_cmp++;
        if (get_rd(0) !== 32'hCAFE0005 || rd_busy[1] !== 1'b1) begin
            n_err++; $display("FAIL areset_pre: got data=%0h busy=%b expected cafe0005/1", get_rd(0), rd_busy[1]);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (get_rd(0) !== 32'h0 || busy_cnt !== 6'd0 || rd_busy[1] !== 1'b0) begin
            n_err++; $display("FAIL areset_immediate: got data=%0h cnt=%0d busy=%b expected 0/0/0", get_rd(0), busy_cnt, rd_busy[1]);
        end
        #10;
        rst_n = 1'b1;
        tick();
        tick();
        #1;
        n_cmp++;
        if (get_rd(0) !== 32'h0 || busy_cnt !== 6'd0) begin
            n_err++; $display("FAIL areset_after: got data=%0h cnt=%0d expected 0/0", get_rd(0), busy_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_scoreboard();
        test_collision();
        test_flush();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
